pad_user_gen: RTL and testbench
===============================

Name: pad_user_gen

Overview:
- Generates the per-datapath tuser flags and valid_last pulses consumed by the horizontal pad filter stage, directly upstream of it.
- Counts channels-in, columns and blocks of the incoming beat stream against a configuration latched at start. Emits column-position and kernel flags for datapath 0.
- Delays the flags through a KERNEL_W_MAX-deep shift chain so that datapath i sees the beat i beats later.

Parameters:
- KERNEL_W_MAX, 7: maximum kernel width; number of datapaths.
- TUSER_WIDTH, 4: user word width.
- INDEX_IS_COLS_1_K2, 0: user bit set when col == cols-1-kw/2.
- INDEX_IS_1x1, 1: user bit set when kernel width is 1.
- INDEX_IS_CIN_LAST, 2: user bit set on the last channel-in beat of a column.
- INDEX_IS_LAST_BLOCK, 3: user bit set during the last block.
- COLS_WIDTH, 10: width of the column count.
- CIN_WIDTH, 10: width of the channels-in count.
- BLOCKS_WIDTH, 10: width of the block count.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- aclken  in  1  global clock enable; low freezes all state.
- start  in  1  latch config and begin a frame; honoured only when busy=0.
- kernel_w_1_in  in  $clog2(KERNEL_W_MAX+1)  kernel width minus 1 (even: 0,2,4,6).
- cols_1_in  in  COLS_WIDTH  columns minus 1.
- cin_1_in  in  CIN_WIDTH  channels-in minus 1.
- blocks_1_in  in  BLOCKS_WIDTH  blocks minus 1.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  upstream beat accepted.
- out_ready  in  1  downstream can advance.
- valid_last  out  1 x [KERNEL_W_MAX-1:0]  per-datapath end-of-channels pulse.
- user  out  TUSER_WIDTH x [KERNEL_W_MAX-1:0]  per-datapath flags.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the final beat.

Behaviour:
- Reset (async, aresetn=0) clears everything immediately:
  - busy, done, in_ready, all valid_last, all user bits and all counters go to 0.
  - Config registers reset to kw=1 (kernel_w_1=0) and all counts 0.
  - Reset mid-frame aborts the frame; done is not produced.
- Start:
  - When aclken & start & !busy, latch kernel_w_1, cols_1, cin_1 and blocks_1.
  - Clear the counters and set busy on the next edge.
  - start while busy is ignored.
- Handshake:
  - in_ready = busy & out_ready & aclken (combinational).
  - beat = in_valid & in_ready.
  - No beats are accepted when busy=0.
- Counters (advance on beat only):
  - cin increments; when cin==cin_1 it wraps to 0 and col increments.
  - When col==cols_1 at wrap, col wraps to 0 and block increments.
  - On the beat where cin==cin_1, col==cols_1 and block==blocks_1: busy clears and done pulses for exactly one cycle on the following edge.
- Stage-0 flags, computed combinationally from the current counters before the increment:
  - kw2 = kernel_w_1>>1.
  - IS_COLS_1_K2 = (kw2!=0) & (col == cols_1-kw2), evaluated with one extra sign bit. If cols_1 < kw2 the bit never asserts.
  - IS_1x1 = (kernel_w_1==0).
  - IS_CIN_LAST = (cin==cin_1).
  - IS_LAST_BLOCK = (block==blocks_1).
- Shift chain:
  - On beat: sr[0] <= flags, sr[i] <= sr[i-1] for i=1..KERNEL_W_MAX-1, and beat_q <= 1.
  - Otherwise sr holds and beat_q <= 0 (when aclken=1).
  - user[i] = sr[i].
  - valid_last[i] = beat_q & sr[i][INDEX_IS_CIN_LAST].
  - Latency: a beat's flags appear at datapath 0 one cycle after acceptance, and at datapath i after i further beats.
  - The chain is not flushed between frames; the residue is shifted out by the next frame's beats.
- aclken=0: no register updates, done/valid_last hold their previous values, in_ready=0.
- Back-to-back frames: start may be asserted in the same cycle done pulses. busy was cleared the edge before, so start is accepted.

Test Plan:
- kw=3 (kernel_w_1=2), cols_1=4, cin_1=1, blocks_1=0, in_valid=1, out_ready=1:
  - 10 beats accepted; IS_CIN_LAST on every 2nd beat.
  - IS_COLS_1_K2 on the beats at col=3.
  - valid_last[0] pulses 5 times.
  - done pulses one cycle after beat 10; busy=0 afterwards.
- kernel_w_1=0, cols_1=2, cin_1=0, blocks_1=1: IS_1x1=1 on all 6 beats, IS_COLS_1_K2 never asserts, IS_LAST_BLOCK on beats 4-6.
- kw=7, cols_1=1 (cols_1 < kw2=3): IS_COLS_1_K2 never asserts; the frame still completes after 2*(cin_1+1) beats.
- Backpressure: toggle out_ready and in_valid randomly on the first test's frame:
  - in_ready tracks out_ready & busy.
  - Exactly 10 beats are counted.
  - user[2] equals the flags of the beat two beats before each beat_q.
- Drop aresetn mid-frame at beat 5: all outputs are 0 immediately, no done; a new start runs a full frame correctly.
- aclken low for 3 cycles mid-frame: counters, sr and done are frozen and in_ready=0; the frame resumes with an unchanged beat count.

Source files
------------

// File: rtl/pad_user_gen.sv
// Per-datapath tuser flags and valid_last pulses for the horizontal pad filter.
// Datapath 0 gets the flags of the beat just accepted; datapath i sees them i beats later.
module pad_user_gen #(
  parameter int KERNEL_W_MAX        = 7,
  parameter int TUSER_WIDTH         = 4,
  parameter int INDEX_IS_COLS_1_K2  = 0,
  parameter int INDEX_IS_1x1        = 1,
  parameter int INDEX_IS_CIN_LAST   = 2,
  parameter int INDEX_IS_LAST_BLOCK = 3,
  parameter int COLS_WIDTH          = 10,
  parameter int CIN_WIDTH           = 10,
  parameter int BLOCKS_WIDTH        = 10
) (
  input  logic                                        aclk,
  input  logic                                        aresetn,
  input  logic                                        aclken,
  input  logic                                        start,
  input  logic [$clog2(KERNEL_W_MAX+1)-1:0]           kernel_w_1_in,
  input  logic [COLS_WIDTH-1:0]                       cols_1_in,
  input  logic [CIN_WIDTH-1:0]                        cin_1_in,
  input  logic [BLOCKS_WIDTH-1:0]                     blocks_1_in,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic                                        out_ready,
  output logic [KERNEL_W_MAX-1:0]                     valid_last,
  output logic [KERNEL_W_MAX-1:0][TUSER_WIDTH-1:0]    user,
  output logic                                        busy,
  output logic                                        done
);

  localparam int KW_W = $clog2(KERNEL_W_MAX+1);

  logic [KW_W-1:0]         kernel_w_1;
  logic [COLS_WIDTH-1:0]   cols_1;
  logic [CIN_WIDTH-1:0]    cin_1;
  logic [BLOCKS_WIDTH-1:0] blocks_1;

  logic [COLS_WIDTH-1:0]   col;
  logic [CIN_WIDTH-1:0]    cin;
  logic [BLOCKS_WIDTH-1:0] block;

  logic                    start_ok;
  logic                    beat;
  logic                    cin_last;
  logic                    col_last;
  logic                    blk_last;
  logic [KW_W-1:0]         kw2;
  logic [TUSER_WIDTH-1:0]  flags_p0;

  logic [KERNEL_W_MAX-1:0][TUSER_WIDTH-1:0] sr_p1;
  logic                                     vld_p1;

  // cols_1 - kw2 with one extra sign bit, so a kernel wider than the row never matches.
  function automatic logic signed [COLS_WIDTH:0] cols_minus_k2(
    input logic [COLS_WIDTH-1:0] c1,
    input logic [KW_W-1:0]       k2
  );
    logic signed [COLS_WIDTH:0] a;
    logic signed [COLS_WIDTH:0] b;
    a = $signed({1'b0, c1});
    b = $signed({{(COLS_WIDTH+1-KW_W){1'b0}}, k2});
    return a - b;
  endfunction

  assign start_ok = aclken & start & ~busy;
  assign in_ready = busy & out_ready & aclken;
  assign beat     = in_valid & in_ready;

  assign cin_last = (cin == cin_1);
  assign col_last = (col == cols_1);
  assign blk_last = (block == blocks_1);
  assign kw2      = kernel_w_1 >> 1;

  // Stage p0: flags of the beat currently presented, from pre-increment counters
  always_comb begin
    flags_p0 = '0;
    flags_p0[INDEX_IS_COLS_1_K2]  = (kw2 != '0) &&
                                    (cols_minus_k2(cols_1, kw2) == $signed({1'b0, col}));
    flags_p0[INDEX_IS_1x1]        = (kernel_w_1 == '0);
    flags_p0[INDEX_IS_CIN_LAST]   = cin_last;
    flags_p0[INDEX_IS_LAST_BLOCK] = blk_last;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      kernel_w_1 <= '0;
      cols_1     <= '0;
      cin_1      <= '0;
      blocks_1   <= '0;
      cin        <= '0;
      col        <= '0;
      block      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (aclken) begin
      done <= 1'b0;
      if (start_ok) begin
        kernel_w_1 <= kernel_w_1_in;
        cols_1     <= cols_1_in;
        cin_1      <= cin_1_in;
        blocks_1   <= blocks_1_in;
        cin        <= '0;
        col        <= '0;
        block      <= '0;
        busy       <= 1'b1;
      end else if (beat) begin
        if (!cin_last) begin
          cin <= cin + 1'b1;
        end else begin
          cin <= '0;
          if (!col_last) begin
            col <= col + 1'b1;
          end else begin
            col <= '0;
            if (!blk_last) begin
              block <= block + 1'b1;
            end else begin
              block <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Stage p1: delay chain; residue of the previous frame is pushed out by new beats
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sr_p1  <= '0;
      vld_p1 <= 1'b0;
    end else if (aclken) begin
      vld_p1 <= beat;
      if (beat) begin
        sr_p1 <= {sr_p1[KERNEL_W_MAX-2:0], flags_p0};
      end
    end
  end

  assign user = sr_p1;

  always_comb begin
    valid_last = '0;
    for (int i = 0; i < KERNEL_W_MAX; i++) begin
      valid_last[i] = vld_p1 & sr_p1[i][INDEX_IS_CIN_LAST];
    end
  end

endmodule

// File: tb/tb_pad_user_gen.sv
// Directed bench for pad_user_gen: flag tables per frame, backpressure, abort and clock-enable freeze.
module tb_pad_user_gen;

  localparam int KMAX = 7;
  localparam int TUW  = 4;

  logic                       aclk = 1'b0;
  logic                       aresetn;
  logic                       aclken;
  logic                       start;
  logic [2:0]                 kernel_w_1_in;
  logic [9:0]                 cols_1_in;
  logic [9:0]                 cin_1_in;
  logic [9:0]                 blocks_1_in;
  logic                       in_valid;
  logic                       in_ready;
  logic                       out_ready;
  logic [KMAX-1:0]            valid_last;
  logic [KMAX-1:0][TUW-1:0]   user;
  logic                       busy;
  logic                       done;

  int n_checks = 0;
  int n_pass   = 0;

  int obs[$];
  int exp_q[$];
  int vl_cnt;
  int nbeats;
  int done_seen;

  pad_user_gen dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .aclken        (aclken),
    .start         (start),
    .kernel_w_1_in (kernel_w_1_in),
    .cols_1_in     (cols_1_in),
    .cin_1_in      (cin_1_in),
    .blocks_1_in   (blocks_1_in),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_ready     (out_ready),
    .valid_last    (valid_last),
    .user          (user),
    .busy          (busy),
    .done          (done)
  );

  always #5 aclk = ~aclk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cmp_table(input string name);
    check_val({name, "_nbeats"}, 64'(obs.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < obs.size(); k++)
      check_val($sformatf("%s_user0_beat%0d", name, k + 1), 64'(obs[k]), 64'(exp_q[k]));
  endtask

  // Runs one frame; rnd toggles handshake inputs, freeze_at stalls aclken after that beat,
  // abort_at drops aresetn after that beat and returns without expecting done.
  task automatic run_frame(input string name, input logic [2:0] kw1, input logic [9:0] c1,
                           input logic [9:0] ci1, input logic [9:0] b1, input bit rnd,
                           input int freeze_at, input int abort_at);
    int rdy_err, vl_err, u2_err, frz_err, cyc;
    bit b, frozen;
    logic [KMAX-1:0][TUW-1:0] snap_u;
    logic [KMAX-1:0]          snap_vl;
    logic                     snap_d, snap_b;
    rdy_err = 0; vl_err = 0; u2_err = 0; frz_err = 0; cyc = 0; frozen = 0;
    obs.delete(); vl_cnt = 0; nbeats = 0; done_seen = 0;
    kernel_w_1_in = kw1; cols_1_in = c1; cin_1_in = ci1; blocks_1_in = b1;
    in_valid = 1'b0; out_ready = 1'b1; start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
    check_val({name, "_busy_after_start"}, 64'(busy), 64'd1);
    while (!done_seen && cyc < 400) begin
      cyc++;
      if (abort_at > 0 && nbeats == abort_at) begin
        aresetn = 1'b0;
        #1;
        check_val({name, "_abort_busy"}, 64'(busy), 64'd0);
        check_val({name, "_abort_done"}, 64'(done), 64'd0);
        check_val({name, "_abort_in_ready"}, 64'(in_ready), 64'd0);
        check_val({name, "_abort_valid_last"}, 64'(valid_last), 64'd0);
        check_val({name, "_abort_user"}, 64'(user), 64'd0);
        @(posedge aclk); #2;
        aresetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(posedge aclk); #1;
          check_val($sformatf("%s_abort_nodone%0d", name, k), 64'(done), 64'd0);
        end
        in_valid = 1'b0;
        return;
      end
      if (freeze_at > 0 && nbeats == freeze_at && !frozen) begin
        frozen = 1;
        snap_u = user; snap_vl = valid_last; snap_d = done; snap_b = busy;
        aclken = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        repeat (3) begin
          #1;
          if (in_ready !== 1'b0) frz_err++;
          @(posedge aclk); #1;
          if (user !== snap_u || valid_last !== snap_vl || done !== snap_d || busy !== snap_b)
            frz_err++;
        end
        aclken = 1'b1;
      end
      if (rnd) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        in_valid  = 1'b1;
        out_ready = 1'b1;
      end
      #1;
      if (in_ready !== (out_ready & busy)) rdy_err++;
      b = in_valid & in_ready;
      @(posedge aclk); #1;
      if (b) begin
        nbeats++;
        obs.push_back(int'(user[0]));
        if (valid_last[0] === 1'b1) vl_cnt++;
        if (nbeats >= 3 && int'(user[2]) != obs[nbeats-3]) u2_err++;
      end else if (valid_last !== '0) begin
        vl_err++;
      end
      if (done === 1'b1) done_seen = 1;
    end
    in_valid = 1'b0;
    check_val({name, "_done_seen"}, 64'(done_seen), 64'd1);
    check_val({name, "_busy_at_done"}, 64'(busy), 64'd0);
    check_val({name, "_in_ready_track"}, 64'(rdy_err), 64'd0);
    check_val({name, "_vl_idle_zero"}, 64'(vl_err), 64'd0);
    if (rnd) check_val({name, "_user2_delay"}, 64'(u2_err), 64'd0);
    if (freeze_at > 0) check_val({name, "_freeze"}, 64'(frz_err + (frozen ? 0 : 1)), 64'd0);
    @(posedge aclk); #1;
    check_val({name, "_done_one_cycle"}, 64'(done), 64'd0);
    check_val({name, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    aresetn = 1'b0; aclken = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    kernel_w_1_in = '0; cols_1_in = '0; cin_1_in = '0; blocks_1_in = '0;
    repeat (2) @(posedge aclk);
    #1;
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_in_ready", 64'(in_ready), 64'd0);
    check_val("rst_valid_last", 64'(valid_last), 64'd0);
    check_val("rst_user", 64'(user), 64'd0);
    #2 aresetn = 1'b1;
    @(posedge aclk); #1;

    // kw=3, 5 cols, 2 cin, 1 block: CIN_LAST on even beats, COLS_1_K2 at col 3 (beats 7,8)
    exp_q = '{8, 12, 8, 12, 8, 12, 9, 13, 8, 12};
    run_frame("t1", 3'd2, 10'd4, 10'd1, 10'd0, 1'b0, 0, 0);
    cmp_table("t1");
    check_val("t1_vl0_pulses", 64'(vl_cnt), 64'd5);

    // 1x1 kernel, 3 cols, 1 cin, 2 blocks: last block on beats 4-6
    exp_q = '{6, 6, 6, 14, 14, 14};
    run_frame("t2", 3'd0, 10'd2, 10'd0, 10'd1, 1'b0, 0, 0);
    cmp_table("t2");
    check_val("t2_vl0_pulses", 64'(vl_cnt), 64'd6);

    // kw=7 wider than the 2-column row: COLS_1_K2 never set, 4 beats
    exp_q = '{8, 12, 8, 12};
    run_frame("t3", 3'd6, 10'd1, 10'd1, 10'd0, 1'b0, 0, 0);
    cmp_table("t3");
    check_val("t3_vl0_pulses", 64'(vl_cnt), 64'd2);

    // First frame again with random backpressure
    exp_q = '{8, 12, 8, 12, 8, 12, 9, 13, 8, 12};
    run_frame("t4", 3'd2, 10'd4, 10'd1, 10'd0, 1'b1, 0, 0);
    cmp_table("t4");
    check_val("t4_vl0_pulses", 64'(vl_cnt), 64'd5);

    // Abort after beat 5, then a full frame from clean state
    run_frame("t5a", 3'd2, 10'd4, 10'd1, 10'd0, 1'b0, 0, 5);
    check_val("t5a_beats_before_abort", 64'(nbeats), 64'd5);
    run_frame("t5b", 3'd2, 10'd4, 10'd1, 10'd0, 1'b0, 0, 0);
    cmp_table("t5b");
    check_val("t5b_vl0_pulses", 64'(vl_cnt), 64'd5);

    // Clock enable low for 3 cycles after beat 4
    run_frame("t6", 3'd2, 10'd4, 10'd1, 10'd0, 1'b0, 4, 0);
    cmp_table("t6");
    check_val("t6_vl0_pulses", 64'(vl_cnt), 64'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
